// File: rtl/add_4_seq_if.sv
// Request/response bundle for the nibble-serial wide adder.
// The master modport is the requesting datapath, the slave modport is the sequencer.
interface add_4_seq_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         cy_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cy_out;
   logic         ovf;
   logic         busy;

   modport master (
      output in_valid, a, b, sub, cy_in, out_ready,
      input  in_ready, out_valid, sum, cy_out, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, sub, cy_in, out_ready,
      output in_ready, out_valid, sum, cy_out, ovf, busy
   );
endinterface

// File: rtl/add_4_seq.sv
// Wide add/subtract built from one 4-bit adder, one nibble per cycle, LSB first; result after NIBBLES cycles.
// Result is held in DONE until out_ready; no new request is accepted until the result is taken.
module add_4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cy_in,
   output logic [3:0] s,
   output logic       cy_4
);
   logic [4:0] t;

   assign t    = {1'b0, x} + {1'b0, y} + {4'b0000, cy_in};
   assign s    = t[3:0];
   assign cy_4 = t[4];
endmodule

module add_4_seq #(
   parameter int NIBBLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   add_4_seq_if.slave  bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic          carry;
   logic          a_msb;
   logic          b_msb;
   logic [W-1:0]  sum_r;
   logic          cy_out_r;
   logic          ovf_r;

   logic [3:0]    x_nib;
   logic [3:0]    y_nib;
   logic [3:0]    s_nib;
   logic          cy_4;

   assign x_nib = a_r[4*idx +: 4];
   assign y_nib = b_r[4*idx +: 4];

   add_4 u_add_4 (
      .x     (x_nib),
      .y     (y_nib),
      .cy_in (carry),
      .s     (s_nib),
      .cy_4  (cy_4)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         a_r      <= '0;
         b_r      <= '0;
         carry    <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         sum_r    <= '0;
         cy_out_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  state <= RUN;
                  idx   <= '0;
                  a_r   <= bus.a;
                  // Subtract is A + ~B + 1, so invert B here and force the carry.
                  b_r   <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub ? 1'b1 : bus.cy_in;
                  a_msb <= bus.a[W-1];
                  b_msb <= bus.sub ? ~bus.b[W-1] : bus.b[W-1];
               end
            end
            RUN: begin
               sum_r[4*idx +: 4] <= s_nib;
               carry             <= cy_4;
               if (idx == LAST_IDX) begin
                  state    <= DONE;
                  cy_out_r <= cy_4;
                  ovf_r    <= (a_msb == b_msb) && (s_nib[3] != a_msb);
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == RUN) || (state == DONE);
   assign bus.sum       = sum_r;
   assign bus.cy_out    = cy_out_r;
   assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_add_4_seq.sv
// Bench for add_4_seq at the default width: directed vectors, expected results queued at issue
// and popped by a monitor at each output handshake.
module tb_add_4_seq;
   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t q[$];

   add_4_seq_if #(.NIBBLES(4)) bus ();

   add_4_seq #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every completed output handshake consumes one queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0h expected=none", bus.sum);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", 32'(bus.sum), 32'(e.s));
            chk("cy_out", 32'(bus.cy_out), 32'(e.c));
            chk("ovf", 32'(bus.ovf), 32'(e.o));
         end
      end
   end

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv,
                       input bit push, input logic [15:0] es, input logic ec, input logic eo);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout actual=0 expected=1");
      end
      bus.a        = av;
      bus.b        = bv;
      bus.sub      = sv;
      bus.cy_in    = cv;
      bus.in_valid = 1'b1;
      if (push) q.push_back('{es, ec, eo});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) begin
         checks++;
         failures++;
         $display("FAIL out_valid_timeout actual=0 expected=1");
      end
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv,
                         input logic [15:0] es, input logic ec, input logic eo, output int lat);
      send(av, bv, sv, cv, 1'b1, es, ec, eo);
      wait_valid(lat);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      bus.cy_in     = 1'b0;
      bus.out_ready = 1'b1;

      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_cy_out", 32'(bus.cy_out), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Plain add with latency measured from the accept edge.
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, lat);
      chk("latency", 32'(lat), 32'd4);
      chk("idle_after_handshake", 32'(bus.in_ready), 32'd1);

      run_op(16'h000F, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, lat);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, lat);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, lat);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, lat);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, lat);
      run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, lat);

      // Backpressure plus a stray request during RUN.
      bus.out_ready = 1'b0;
      send(16'h0100, 16'h00FF, 1'b0, 1'b0, 1'b1, 16'h01FF, 1'b0, 1'b0);
      chk("busy_run", 32'(bus.busy), 32'd1);
      bus.a        = 16'hFFFF;
      bus.b        = 16'hFFFF;
      bus.cy_in    = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_run", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_sum", 32'(bus.sum), 32'h01FF);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_hs_sum_kept", 32'(bus.sum), 32'h01FF);

      // Abort after two RUN cycles; nothing may be reported for this request.
      send(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_sum", 32'(bus.sum), 32'd0);
      chk("abort_cy_out", 32'(bus.cy_out), 32'd0);
      chk("abort_ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, lat);
      chk("latency_after_reset", 32'(lat), 32'd4);

      @(posedge clk); #1;
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/add_4_seq.md
# add_4_seq

Multi-cycle sequencer that performs wide add/subtract operations by driving one `add_4` nibble adder instance, one nibble per clock. It is a parameterised wide adder that reuses the existing 4-bit adder as its only arithmetic resource. Operands arrive on a valid/ready handshake. Results leave on a second valid/ready handshake. It sits between a requesting datapath and the shared `add_4` primitive.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles. W = 4*NIBBLES. Legal range is 1..16.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: request carries valid operands.
- `in_ready`, output, 1: block can accept a request. Equals (state == IDLE).
- `a`, input, W: operand A.
- `b`, input, W: operand B.
- `sub`, input, 1: 1 selects A − B, 0 selects A + B + `cy_in`.
- `cy_in`, input, 1: carry-in for add. Ignored when `sub`=1.
- `out_valid`, output, 1: result is valid and held stable.
- `out_ready`, input, 1: consumer accepts the result.
- `sum`, output, W: result.
- `cy_out`, output, 1: final carry out of the MSB nibble. For subtract, 1 means no borrow.
- `ovf`, output, 1: two's-complement signed overflow.
- `busy`, output, 1: high in RUN or DONE.

## Operation
- One internal `add_4` instance. Its inputs are: `x` = A nibble[idx], `y` = B' nibble[idx], `cy_in` = carry register.
- States and transitions:
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE after the nibble with idx = NIBBLES−1 is written.
  - DONE → IDLE on `out_valid && out_ready`.
- On accept:
  - Latch `a` into A_r.
  - Latch B' = `sub` ? ~`b` : `b`.
  - Set the carry register to `sub` ? 1 : `cy_in`.
  - Set idx = 0.
  - Latch the MSB of A_r and the MSB of B' for the overflow computation.
- On each RUN cycle:
  - `sum`[4*idx +: 4] ← `s`.
  - Carry register ← `cy_4`.
  - idx ← idx + 1.
  - Nibbles are processed LSB first.
- On entering DONE:
  - `cy_out` = the last `cy_4`.
  - `ovf` = (A_msb == B'_msb) && (sum_msb != A_msb).
  - `out_valid` = 1.
- DONE holds `sum`, `cy_out`, `ovf` and `out_valid` stable until the handshake completes.
- After the output handshake, `sum`, `cy_out` and `ovf` keep their values, and `out_valid` drops to 0.
- `in_valid` is ignored outside IDLE. `a`, `b`, `sub` and `cy_in` are sampled only on the accept edge.
- Arithmetic is modulo 2^W. With `sub`=1, `cy_in` has no effect.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state = IDLE, so `in_ready` = 1.
  - `out_valid`, `busy`, `cy_out`, `ovf` = 0.
  - `sum` = 0, idx = 0, carry register = 0, operand registers = 0.
- Latency: request accepted at edge E0 ⇒ `out_valid` = 1 after edge E0+NIBBLES. That is exactly NIBBLES cycles, or 4 cycles at the default.
- `out_valid` and `out_ready` both high at edge Ed ⇒ IDLE after Ed, and `in_ready` = 1 in the following cycle.
  - There is no same-edge restart, so peak throughput is one op per NIBBLES+2 cycles.
- Backpressure: with `out_ready`=0, DONE is held indefinitely and `in_ready` stays 0.
- `out_ready` high while not in DONE has no effect.
- Reset asserted mid-RUN or in DONE:
  - The operation aborts immediately and all outputs go to their reset values.
  - No partial result is ever flagged valid.
- NIBBLES=1: a single RUN cycle.

## Test plan
- Add, default params: `a`=0x1234, `b`=0x4321, `sub`=0, `cy_in`=0 → `sum`=0x5555, `cy_out`=0, `ovf`=0. `out_valid` rises 4 cycles after accept.
- Carry-in and ripple: 0x000F + 0x0000 with `cy_in`=1 → 0x0010, `cy_out`=0. Then 0xFFFF + 0x0001 → 0x0000, `cy_out`=1, `ovf`=0.
- Signed overflow: 0x7FFF + 0x0001 → 0x8000, `ovf`=1. Then 0x8000 + 0x8000 → 0x0000, `cy_out`=1, `ovf`=1.
- Subtract:
  - 0x0005 − 0x0007 with `cy_in`=1 (must be ignored) → 0xFFFE, `cy_out`=0.
  - 0x0007 − 0x0005 → 0x0002, `cy_out`=1.
- Handshake and backpressure:
  - Hold `out_ready`=0 for 10 cycles → `sum` and `out_valid` remain stable, `in_ready`=0.
  - `in_valid` pulsed with different operands during RUN → ignored, and the result is unchanged.
- Reset mid-operation: assert `rst_n`=0 after 2 RUN cycles → outputs go to 0 asynchronously and `in_ready`=1. A fresh request then completes correctly.
